pc_redirect_unit: RTL

- Owns the fetch PC for the MIPS pipeline and applies control-flow redirects resolved in EX.
- Consumes the opfunc_t classification (OJR, OBEQ, OBNE, OJ, OJAL, OTHERR, OTHERI, OTHERJ) that decode attaches to each instruction.
- Handshakes with the instruction cache: ihit acknowledges a fetch, and the address must stay stable until it does.
- Produces the JAL link value (pc_ex+4) for the writeback NPC source, and the IF/ID flush.

---
 rtl/pc_redirect_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC and applies EX-resolved redirects.
// A redirect that meets an icache miss is parked in WAIT until ihit, so the
// fetch address stays stable for the outstanding request.
// Optional build macro BRANCH_STATS_EN adds saturating branch/taken counters.
module pc_redirect_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          PC_W    = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dstall,
  input  logic            halt,
  input  logic            valid_ex,
  input  logic [2:0]      opfunc_ex,
  input  logic [PC_W-1:0] pc_ex,
  input  logic [15:0]     imm_ex,
  input  logic [25:0]     jaddr_ex,
  input  logic [PC_W-1:0] rs_data_ex,
  input  logic            zero_ex,
  output logic [PC_W-1:0] pc_o,
  output logic            imemREN,
  output logic [PC_W-1:0] npc_o,
  output logic            flush_o,
  output logic            pending_o,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     taken_cnt_o,
`endif
  output logic [1:0]      dbg_state_o
);

  // opfunc_t encoding as attached by decode
  localparam logic [2:0] OJR    = 3'd0;
  localparam logic [2:0] OBEQ   = 3'd1;
  localparam logic [2:0] OBNE   = 3'd2;
  localparam logic [2:0] OJ     = 3'd3;
  localparam logic [2:0] OJAL   = 3'd4;
  localparam logic [2:0] OTHERR = 3'd5;
  localparam logic [2:0] OTHERI = 3'd6;
  localparam logic [2:0] OTHERJ = 3'd7;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_q;
  logic            imemren_q;

  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] target;
  logic            taken;
  logic            redirect;

  // Link value and the two immediate-based targets; all adds wrap mod 2^32
  always_comb begin
    npc_o  = pc_ex + 32'd4;
    br_tgt = npc_o + {{14{imm_ex[15]}}, imm_ex, 2'b00};
    j_tgt  = {npc_o[31:28], jaddr_ex, 2'b00};
  end

  // Taken decision and target selection for the EX instruction
  always_comb begin
    taken  = 1'b0;
    target = br_tgt;
    case (opfunc_ex)
      OJR: begin
        taken  = 1'b1;
        target = rs_data_ex;
      end
      OBEQ: begin
        taken  = zero_ex;
        target = br_tgt;
      end
      OBNE: begin
        taken  = !zero_ex;
        target = br_tgt;
      end
      OJ, OJAL: begin
        taken  = 1'b1;
        target = j_tgt;
      end
      OTHERR, OTHERI, OTHERJ: begin
        taken  = 1'b0;
      end
      default: begin
        taken  = 1'b0;
      end
    endcase
  end

  assign redirect = valid_ex & taken & !dstall & (state_q == S_RUN);

  // Flush: a redirect accepted in RUN (halt has priority), or WAIT retiring
  // its pending target as the stale instruction returns
  always_comb begin
    flush_o = 1'b0;
    if (state_q == S_RUN && !halt && redirect) flush_o = 1'b1;
    if (state_q == S_WAIT && ihit)             flush_o = 1'b1;
  end

  assign pc_o        = pc_q;
  assign imemREN     = imemren_q;
  assign pending_o   = (state_q == S_WAIT);
  assign dbg_state_o = state_q;

  // Fetch FSM: PC sequencing, redirect parking and sticky halt
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_RUN;
      pc_q      <= PC_INIT;
      pend_q    <= '0;
      imemren_q <= 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (halt) begin
            state_q   <= S_HALTED;
            imemren_q <= 1'b0;
          end else if (redirect && ihit) begin
            pc_q <= target;
          end else if (redirect) begin
            pend_q  <= target;
            state_q <= S_WAIT;
          end else if (ihit && !dstall) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        S_WAIT: begin
          if (ihit) begin
            pc_q    <= pend_q;
            state_q <= S_RUN;
          end
        end
        S_HALTED: begin
          imemren_q <= 1'b0;
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] taken_cnt_q;

  // Saturating counters: conditional branches seen in RUN, accepted redirects
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (state_q == S_RUN && valid_ex && !dstall &&
          (opfunc_ex == OBEQ || opfunc_ex == OBNE) && br_cnt_q != 32'hFFFF_FFFF)
        br_cnt_q <= br_cnt_q + 32'd1;
      if (redirect && !halt && taken_cnt_q != 32'hFFFF_FFFF)
        taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign br_cnt_o    = br_cnt_q;
  assign taken_cnt_o = taken_cnt_q;
`endif

endmodule
